// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, defaults and helpers for the UART TX arbiter
// Contents:
//   arb_state_t      arbiter FSM state encoding
//   DEF_MAX_LEN      default bytes per grant before forced release
//   DEF_TIMEOUT_CYC  default watchdog limit in clocks
//   cnt_width()      bit width needed to hold values 0..n-1 (minimum 1)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND    = 2'b01,
    ST_WAIT    = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_t;

  localparam int DEF_MAX_LEN     = 16;
  localparam int DEF_TIMEOUT_CYC = 20000;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
// Ports:
//   i_req    request vector, one bit per requester
//   i_ptr    index of the previous winner; search starts at i_ptr+1
//   o_grant  one-hot winner, zero when no request
//   o_idx    index of the winner
//   o_any    at least one request is present
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_k;

  // Walk ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the first hit wins,
  // so the previous owner is considered last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_k]) begin
        o_any        = 1'b1;
        o_idx        = w_k;
        o_grant[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one uart_tx among byte-stream requesters
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   i_req      per-requester byte valid, held until acked
//   i_byte     requester k's byte on [8k+7:8k]
//   i_last     per-requester last-byte-of-frame flag
//   o_ack      one-cycle pulse, byte accepted
//   o_grant    one-hot transmitter owner, zero when idle
//   o_tx_dv    one-cycle start pulse to uart_tx
//   o_tx_byte  byte to uart_tx
//   i_tx_done  byte-complete pulse from uart_tx
//   o_busy     arbiter not idle
//   o_err      one-cycle pulse on watchdog abort
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_byte,
  input  logic [NUM_REQ-1:0]     i_last,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int               IDX_W     = cnt_width(NUM_REQ);
  localparam int               WD_W      = cnt_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = '1;
  localparam logic [7:0]       LEN_LIMIT = 8'(MAX_LEN);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gidx;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_tx_dv;
  logic [7:0]          r_tx_byte;
  logic                r_last;
  logic [7:0]          r_cnt;
  logic [WD_W-1:0]     r_wd;
  logic                r_err;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic                w_g_req;
  logic                w_g_last;
  logic [7:0]          w_g_byte;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Signals of the requester that currently holds the grant.
  assign w_g_req  = i_req[r_gidx];
  assign w_g_last = i_last[r_gidx];
  assign w_g_byte = i_byte[{r_gidx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Pulse outputs drop back to zero unless a state sets them this cycle.
      r_ack   <= '0;
      r_tx_dv <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_grant;
            r_gidx  <= w_pick_idx;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_g_req) begin
            r_tx_byte <= w_g_byte;
            r_tx_dv   <= 1'b1;
            r_ack     <= r_grant;
            r_last    <= w_g_last;
            r_cnt     <= r_cnt + 8'd1;
            r_wd      <= '0;
            r_state   <= ST_WAIT;
          end else begin
            // Owner withdrew mid-frame: give the transmitter up without sending.
            r_state <= ST_RELEASE;
          end
        end

        ST_WAIT: begin
          if (r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
          end
          // Done is checked first so a coincident timeout is not an error.
          if (i_tx_done) begin
            if (r_last || (r_cnt == LEN_LIMIT)) begin
              r_state <= ST_RELEASE;
            end else begin
              r_state <= ST_SEND;
            end
          end else if (r_wd == WD_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          r_grant <= '0;
          r_ptr   <= r_gidx;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_grant   = r_grant;
  assign o_tx_dv   = r_tx_dv;
  assign o_tx_byte = r_tx_byte;
  assign o_busy    = r_busy;
  assign o_err     = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard testbench for uart_tx_arb
module tb_uart_tx_arb;

  localparam int NREQ     = 4;
  localparam int MAXL     = 4;
  localparam int TIMEOUT  = 40;
  localparam int DONE_DLY = 6;

  logic            clk;
  logic            reset;
  logic [3:0]      i_req;
  logic [31:0]     i_byte;
  logic [3:0]      i_last;
  logic [3:0]      o_ack;
  logic [3:0]      o_grant;
  logic            o_tx_dv;
  logic [7:0]      o_tx_byte;
  logic            i_tx_done;
  logic            o_busy;
  logic            o_err;

  uart_tx_arb #(
    .NUM_REQ     (NREQ),
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_byte    (i_byte),
    .i_last    (i_last),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_tx_dv   (o_tx_dv),
    .o_tx_byte (o_tx_byte),
    .i_tx_done (i_tx_done),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [3:0] grant;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         idx;
    logic       last;
    logic [7:0] data;
  } rq_t;

  ev_t  exp_q[$];
  rq_t  rq[$];

  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   last_dv_cyc;
  int   drop_done;
  logic late_done;
  logic [3:0] drop_on_grant;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic l);
    rq_t e;
    e.idx  = k;
    e.data = d;
    e.last = l;
    rq.push_back(e);
  endtask

  task automatic expect_tx(input logic [3:0] g, input logic [7:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.grant  = g;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [3:0] g);
    ev_t e;
    e.is_err = 1'b1;
    e.grant  = g;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an error.
  task automatic check_ev(input logic is_err);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got err=%0d grant=%b byte=%h, required none", is_err, o_grant, o_tx_byte);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(is_err), 32'(e.is_err));
      chk("event_grant", 32'(o_grant), 32'(e.grant));
      if (!is_err) begin
        chk("tx_byte", 32'(o_tx_byte), 32'(e.data));
        chk("ack", 32'(o_ack), 32'(e.grant));
      end else begin
        chk("err_latency", 32'(cyc - last_dv_cyc), 32'(TIMEOUT));
      end
    end
  endtask

  initial begin
    last_dv_cyc = 0;
    forever begin
      @(negedge clk);
      if (o_tx_dv) begin
        last_dv_cyc = cyc;
        check_ev(1'b0);
      end
      if (o_err) check_ev(1'b1);
    end
  end

  // uart_tx model: done pulse DONE_DLY cycles after each start, unless dropped.
  initial begin
    i_tx_done = 1'b0;
    forever begin : done_model
      int cnt;
      @(posedge clk);
      #1;
      i_tx_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end
      if (late_done) begin
        late_done = 1'b0;
        i_tx_done = 1'b1;
      end
      if (o_tx_dv) begin
        if (drop_done > 0) drop_done--;
        else cnt = DONE_DLY;
      end
    end
  end

  // Requester models: each presents the head of its own entries until acked.
  initial begin
    i_req  = '0;
    i_byte = '0;
    i_last = '0;
    forever begin : req_model
      logic [3:0]  rv;
      logic [3:0]  lv;
      logic [31:0] bv;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (o_ack[k]) begin
          for (int i = 0; i < rq.size(); i++) begin
            if (rq[i].idx == k) begin
              rq.delete(i);
              break;
            end
          end
        end
        if (o_grant[k] && drop_on_grant[k]) begin
          for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].idx == k) rq.delete(i);
          end
          drop_on_grant[k] = 1'b0;
        end
      end
      rv = '0;
      lv = '0;
      bv = '0;
      for (int i = 0; i < rq.size(); i++) begin
        if (!rv[rq[i].idx]) begin
          rv[rq[i].idx]          = 1'b1;
          lv[rq[i].idx]          = rq[i].last;
          bv[rq[i].idx*8 +: 8]   = rq[i].data;
        end
      end
      i_req  = rv;
      i_last = lv;
      i_byte = bv;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_grant"}, 32'(o_grant), 32'h0);
    chk({nm, "_busy"}, 32'(o_busy), 32'h0);
    chk({nm, "_tx_dv"}, 32'(o_tx_dv), 32'h0);
    chk({nm, "_ack"}, 32'(o_ack), 32'h0);
    chk({nm, "_err"}, 32'(o_err), 32'h0);
    chk({nm, "_tx_byte"}, 32'(o_tx_byte), 32'h0);
  endtask

  task automatic drain(input string nm, input int maxc);
    int n;
    n = 0;
    while ((rq.size() != 0 || exp_q.size() != 0 || o_busy) && n < maxc) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({nm, "_completes"}, 32'(n < maxc), 32'h1);
    chk({nm, "_grant_cleared"}, 32'(o_grant), 32'h0);
  endtask

  task automatic wait_grant(input logic [3:0] g, input int maxc, input string nm);
    int n;
    n = 0;
    while (o_grant !== g && n < maxc) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(nm, 32'(o_grant), 32'(g));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : main
    int   n;
    logic busy_seen;
    n_cmp         = 0;
    n_bad         = 0;
    drop_done     = 0;
    late_done     = 1'b0;
    drop_on_grant = '0;
    reset         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Round robin: pointer starts at 3, so 0 wins first.
    expect_tx(4'b0001, 8'h10);
    expect_tx(4'b0010, 8'h11);
    expect_tx(4'b1000, 8'h13);
    expect_tx(4'b0001, 8'h20);
    expect_tx(4'b0010, 8'h21);
    expect_tx(4'b1000, 8'h23);
    send(0, 8'h10, 1'b1);
    send(0, 8'h20, 1'b1);
    send(1, 8'h11, 1'b1);
    send(1, 8'h21, 1'b1);
    send(3, 8'h13, 1'b1);
    send(3, 8'h23, 1'b1);
    drain("round_robin", 1000);

    // Single 3-byte frame from requester 2.
    expect_tx(4'b0100, 8'h41);
    expect_tx(4'b0100, 8'h42);
    expect_tx(4'b0100, 8'h43);
    send(2, 8'h41, 1'b0);
    send(2, 8'h42, 1'b0);
    send(2, 8'h43, 1'b1);
    drain("single_frame", 1000);
    chk("single_frame_busy", 32'(o_busy), 32'h0);

    // Length limit: requester 1 cut after 4 bytes, requester 0 served, then the rest.
    expect_tx(4'b0010, 8'h51);
    expect_tx(4'b0010, 8'h52);
    expect_tx(4'b0010, 8'h53);
    expect_tx(4'b0010, 8'h54);
    expect_tx(4'b0001, 8'h61);
    expect_tx(4'b0001, 8'h62);
    expect_tx(4'b0010, 8'h55);
    expect_tx(4'b0010, 8'h56);
    for (int i = 0; i < 6; i++) send(1, 8'h51 + 8'(i), (i == 5));
    wait_grant(4'b0010, 50, "length_first_grant");
    send(0, 8'h61, 1'b0);
    send(0, 8'h62, 1'b1);
    drain("length_limit", 2000);

    // Watchdog: first byte never completes; requester 3 is served afterwards.
    drop_done = 1;
    expect_tx(4'b0100, 8'h71);
    expect_err(4'b0100);
    expect_tx(4'b1000, 8'h81);
    send(2, 8'h71, 1'b1);
    send(3, 8'h81, 1'b1);
    drain("watchdog", 1000);
    chk("watchdog_err_low", 32'(o_err), 32'h0);

    // Abandon: requester 1 withdraws as soon as it is granted.
    drop_on_grant = 4'b0010;
    send(1, 8'h91, 1'b1);
    wait_grant(4'b0010, 50, "abandon_grant");
    drain("abandon", 200);
    chk("abandon_err", 32'(o_err), 32'h0);

    // Reset during WAIT, then a late done, then requester 0 must win first.
    drop_done = 1;
    expect_tx(4'b0100, 8'hA1);
    send(2, 8'hA1, 1'b1);
    n = 0;
    while (!o_tx_dv && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reset_mid_dv_seen", 32'(o_tx_dv), 32'h1);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_mid_busy_before", 32'(o_busy), 32'h1);
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b1;
    late_done = 1'b1;
    busy_seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      if (o_busy || o_grant != 4'b0000) busy_seen = 1'b1;
    end
    chk("late_done_stays_idle", 32'(busy_seen), 32'h0);
    expect_tx(4'b0001, 8'hB0);
    expect_tx(4'b0100, 8'hB2);
    expect_tx(4'b1000, 8'hB3);
    send(0, 8'hB0, 1'b1);
    send(2, 8'hB2, 1'b1);
    send(3, 8'hB3, 1'b1);
    drain("after_reset", 1000);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single `uart_tx` byte transmitter among `NUM_REQ` byte-stream requesters (memory readback, status reporter, loopback echo, and so on). It grants the transmitter for a whole frame, sequences each byte through the `i_Tx_DV`/`o_Tx_Done` handshake, and limits frame length for fairness. A watchdog aborts a frame when `o_Tx_Done` never arrives. It sits between the requesters and the `uart_tx` instance in the top-level RX/TX test block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_LEN`, 16: bytes per grant before forced release, 1..255.
- `TIMEOUT_CYC`, 20000: clocks allowed between `o_tx_dv` and `i_tx_done` before abort; must exceed one UART byte time.

Ports:
- `clk`  in  1  single system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  NUM_REQ  per requester: byte valid. Hold high with a stable byte until acked.
- `i_byte`  in  8*NUM_REQ  requester k's byte is `[8k+7:8k]`.
- `i_last`  in  NUM_REQ  byte is the last of its frame. Qualified by `i_req`.
- `o_ack`  out  NUM_REQ  one-cycle pulse: the byte was accepted.
- `o_grant`  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- `o_tx_dv`  out  1  to `uart_tx` `i_Tx_DV`; one-cycle pulse.
- `o_tx_byte`  out  8  to `uart_tx` `i_Tx_Byte`.
- `i_tx_done`  in  1  from `uart_tx` `o_Tx_Done`.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- **Reset values:** all outputs are 0; state is IDLE; the priority pointer is `NUM_REQ-1`, so requester 0 wins first; the byte counter and watchdog are 0.
- **States:** IDLE, SEND, WAIT, RELEASE.
- **IDLE:** if any `i_req` is high, pick the first requester at or after pointer+1 (modulo `NUM_REQ`). Set `o_grant` to it, clear the byte counter, go to SEND. If no request, stay.
- **SEND:**
  - If the granted `i_req` is high: `o_tx_byte` <= its byte, `o_tx_dv` <= 1, `o_ack[g]` <= 1, latch `i_last`, increment the byte counter, clear the watchdog, go to WAIT.
  - If the granted `i_req` is low, the frame is abandoned: go to RELEASE with no transmission.
- **WAIT:** `o_tx_dv` and `o_ack` return to 0. The watchdog increments every cycle.
  - On `i_tx_done`: go to RELEASE if the latched last is 1 or the byte counter equals `MAX_LEN`; otherwise go to SEND.
  - If the watchdog reaches `TIMEOUT_CYC-1` without `i_tx_done`: `o_err` <= 1, go to RELEASE.
  - If `i_tx_done` and timeout occur in the same cycle, done wins and there is no error.
- **RELEASE:** `o_grant` <= 0, pointer <= granted index, go to IDLE.
- **Requests outside the grant:**
  - Requests from non-granted requesters are ignored; they are never acked while another requester holds the grant.
  - A new request arriving during RELEASE is evaluated in the following IDLE cycle.
- **Counter widths:** the byte counter is 8 bits; the watchdog is `$clog2(TIMEOUT_CYC)` bits and saturates, never wrapping.
- **Forced release:** a frame cut at `MAX_LEN` bytes resumes on the requester's next grant. The arbiter does not track frames across grants.
- **Reset mid-operation:** the arbiter returns immediately to reset values. A byte already handed to `uart_tx` completes there; its later `i_tx_done` arrives in IDLE and is ignored.

## Timing
- Request sampled in IDLE at edge t: `o_grant` is valid after t, and `o_tx_dv`/`o_ack` are high for the cycle after edge t+1.
- Back-to-back bytes: `i_tx_done` sampled at edge d gives the next `o_tx_dv` after edge d+1. The requester must present the next byte by edge d+1, which is at least one full byte time after the ack.
- Release to next grant takes two cycles: RELEASE, then IDLE.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- **Package `uart_arb_pkg`:**
  - state encoding constants: IDLE=2'b00, SEND=2'b01, WAIT=2'b10, RELEASE=2'b11;
  - default values of `MAX_LEN` and `TIMEOUT_CYC`;
  - a function for the counter width.
- **Sub-module `uart_rr_pick`:** the combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the one-hot grant and the index. It is reusable by other arbiters in the design.
- **Top-level use:** `uart_tx_arb` instantiates one `uart_rr_pick`. The top level connects `uart_tx` to it unchanged.

## Test plan
- **Single frame:** requester 2 sends a 3-byte frame 0x41, 0x42, 0x43 with `i_last` on the third byte, and the `uart_tx` model returns done. Required: three `o_tx_dv` pulses with those bytes, three `o_ack[2]` pulses, `o_grant` = 4'b0100 throughout, then 0.
- **Round robin:** requesters 0, 1 and 3 hold 1-byte frames continuously. Required: grants in order 0, 1, 3, 0, 1, 3, with no starvation.
- **Length limit:** `MAX_LEN` = 4; requester 1 sends a 6-byte frame while requester 0 is waiting. Required: 4 bytes from requester 1, then requester 0's frame, then the remaining 2 bytes from requester 1.
- **Watchdog:** `i_tx_done` is never returned. Required: `o_err` pulses at `TIMEOUT_CYC` cycles after `o_tx_dv`, `o_grant` clears, and the next requester is served.
- **Abandon:** the granted requester drops `i_req` in SEND. Required: no `o_tx_dv`, release, and `o_err` stays 0.
- **Reset mid-operation:** assert `reset` low during WAIT, then send a late `i_tx_done`. Required: all outputs are 0 immediately, the arbiter stays in IDLE after the late done, and requester 0 is granted first after reset.
